// File: rtl/coefficient_block_builder.sv
// coefficient_block_builder: expands (run, coefficient) pairs into a de-zigzagged
// 8x8 block with DC prediction, and holds it for random-access reads by the IDCT.
// Optional macro COEFFICIENT_BLOCK_BUILDER_DOUBLE_BUFFER_EN adds a second bank so
// filling can continue while the consumer still holds the previous block.
module coefficient_block_builder #(
  parameter int unsigned COEF_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        r_value,
  input  logic [7:0]        coefficient,
  input  logic              is_new_coefficient,
  input  logic              dc_pred_clr,
  output logic              block_ready,
  input  logic [5:0]        rd_addr,
  output logic [COEF_W-1:0] rd_data,
  input  logic              block_ack,
  output logic              overflow_err
);

`ifdef COEFFICIENT_BLOCK_BUILDER_DOUBLE_BUFFER_EN
  localparam int unsigned NB = 2;
  localparam int unsigned AW = 7;
`else
  localparam int unsigned NB = 1;
  localparam int unsigned AW = 6;
`endif
  localparam int unsigned DEPTH = NB * 64;

  // zigzag scan position k -> natural row-major address
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic {S_FILL, S_FULL} state_t;

  state_t              r_state, w_state_n;
  logic [6:0]          r_k, w_k_n;
  logic [COEF_W-1:0]   r_pred, w_pred_n;
  logic                r_err, w_err_set;
  logic                r_ready, w_ready_n;
  logic [COEF_W-1:0]   r_mem [DEPTH];
  logic [DEPTH-1:0]    r_mask, w_mask_n;
  logic                w_we, w_done, w_rel, w_can_fill;
  logic [5:0]          w_wpos;
  logic [COEF_W-1:0]   w_wdata, w_sext;
  logic [6:0]          w_pos, w_zrl;
  logic [AW-1:0]       w_waddr, w_raddr;

  assign w_sext = {{(COEF_W-8){coefficient[7]}}, coefficient};
  assign w_pos  = r_k + 7'(r_value);
  assign w_zrl  = r_k + 7'd16;

`ifdef COEFFICIENT_BLOCK_BUILDER_DOUBLE_BUFFER_EN
  logic       r_fb, r_rb, w_fb_n, w_rb_n, w_wbank, w_other_free;
  logic [1:0] r_full, w_full_n;
  // a strobe during FULL+ack lands in the bank being freed
  assign w_wbank      = (r_state == S_FULL) ? r_rb : r_fb;
  assign w_rel        = block_ack && r_full[r_rb];
  assign w_other_free = !r_full[~r_fb] || (w_rel && (r_rb != r_fb));
  assign w_waddr      = {w_wbank, w_wpos};
  assign w_raddr      = {r_rb, rd_addr};
`else
  assign w_rel        = block_ack && (r_state == S_FULL);
  assign w_waddr      = w_wpos;
  assign w_raddr      = rd_addr;
`endif

  assign w_can_fill   = (r_state == S_FILL) || w_rel;
  assign block_ready  = r_ready;
  assign overflow_err = r_err;
  assign rd_data      = r_mask[w_raddr] ? r_mem[w_raddr] : '0;

  // next-state: pair decode, run expansion, completion and release
  always_comb begin
    w_state_n = r_state;
    w_k_n     = r_k;
    w_pred_n  = dc_pred_clr ? '0 : r_pred;
    w_err_set = 1'b0;
    w_we      = 1'b0;
    w_wpos    = 6'd0;
    w_wdata   = w_sext;
    w_done    = 1'b0;
    if (is_new_coefficient) begin
      if (!w_can_fill) begin
        w_err_set = 1'b1;
      end else if (r_k == 7'd0) begin
        w_pred_n = w_pred_n + w_sext;
        w_we     = 1'b1;
        w_wdata  = w_pred_n;
        w_k_n    = 7'd1;
      end else if (coefficient != 8'd0) begin
        if (w_pos > 7'd63) begin
          w_err_set = 1'b1;
          w_done    = 1'b1;
        end else begin
          w_we   = 1'b1;
          w_wpos = ZZ[w_pos[5:0]];
          w_k_n  = w_pos + 7'd1;
          w_done = (w_pos == 7'd63);
        end
      end else if (r_value == 4'hF) begin
        w_k_n     = w_zrl;
        w_done    = (w_zrl >= 7'd64);
        w_err_set = (w_zrl > 7'd64);
      end else begin
        w_done = 1'b1;
      end
    end
    if (w_rel) w_state_n = S_FILL;
    w_mask_n = r_mask;
`ifdef COEFFICIENT_BLOCK_BUILDER_DOUBLE_BUFFER_EN
    w_fb_n   = r_fb;
    w_rb_n   = r_rb;
    w_full_n = r_full;
    if (w_rel) begin
      w_full_n[r_rb] = 1'b0;
      w_rb_n         = ~r_rb;
      if (r_state == S_FULL) w_fb_n = r_rb;
      if (r_rb) w_mask_n[127:64] = '0;
      else      w_mask_n[63:0]   = '0;
    end
    if (w_done) begin
      w_k_n          = 7'd0;
      w_full_n[r_fb] = 1'b1;
      if (w_other_free) w_fb_n = ~r_fb;
      else              w_state_n = S_FULL;
    end
    w_ready_n = w_full_n[w_rb_n];
`else
    if (w_rel) w_mask_n = '0;
    if (w_done) begin
      w_k_n     = 7'd0;
      w_state_n = S_FULL;
    end
    w_ready_n = (w_state_n == S_FULL);
`endif
    if (w_we) w_mask_n[w_waddr] = 1'b1;
  end

  // control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FILL;
      r_k     <= 7'd0;
      r_pred  <= '0;
      r_err   <= 1'b0;
      r_ready <= 1'b0;
      r_mask  <= '0;
`ifdef COEFFICIENT_BLOCK_BUILDER_DOUBLE_BUFFER_EN
      r_fb    <= 1'b0;
      r_rb    <= 1'b0;
      r_full  <= 2'b00;
`endif
    end else begin
      r_state <= w_state_n;
      r_k     <= w_k_n;
      r_pred  <= w_pred_n;
      r_err   <= r_err | w_err_set;
      r_ready <= w_ready_n;
      r_mask  <= w_mask_n;
`ifdef COEFFICIENT_BLOCK_BUILDER_DOUBLE_BUFFER_EN
      r_fb    <= w_fb_n;
      r_rb    <= w_rb_n;
      r_full  <= w_full_n;
`endif
    end
  end

  // coefficient storage; the valid mask decides what is visible
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

endmodule

// File: tb/tb_coefficient_block_builder.sv
// Directed table-driven bench for coefficient_block_builder.
module tb_coefficient_block_builder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  r_value;
  logic [7:0]  coefficient;
  logic        is_new_coefficient;
  logic        dc_pred_clr;
  logic        block_ready;
  logic [5:0]  rd_addr;
  logic [10:0] rd_data;
  logic        block_ack;
  logic        overflow_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        stb;
    logic [3:0]  r;
    logic [7:0]  c;
    logic        clr;
    logic        ack;
    logic [5:0]  addr;
    logic        chk_d;
    logic [10:0] exp_d;
    logic        exp_rdy;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  coefficient_block_builder #(.COEF_W(11)) dut (
    .clk(clk), .rst(rst), .r_value(r_value), .coefficient(coefficient),
    .is_new_coefficient(is_new_coefficient), .dc_pred_clr(dc_pred_clr),
    .block_ready(block_ready), .rd_addr(rd_addr), .rd_data(rd_data),
    .block_ack(block_ack), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic stb, input logic [3:0] r, input logic [7:0] c,
                              input logic clr, input logic ack, input logic [5:0] addr,
                              input logic chk_d, input logic [10:0] exp_d,
                              input logic rdy, input logic err);
    vec_t v;
    v.stb = stb; v.r = r; v.c = c; v.clr = clr; v.ack = ack; v.addr = addr;
    v.chk_d = chk_d; v.exp_d = exp_d; v.exp_rdy = rdy; v.exp_err = err;
    return v;
  endfunction

  task automatic pair(input logic [3:0] r, input logic [7:0] c, input logic rdy, input logic err);
    tbl.push_back(mk(1'b1, r, c, 1'b0, 1'b0, 6'd0, 1'b0, 11'd0, rdy, err));
  endtask

  task automatic rd(input logic [5:0] a, input logic [10:0] d, input logic rdy, input logic err);
    tbl.push_back(mk(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, a, 1'b1, d, rdy, err));
  endtask

  task automatic ack(input logic rdy, input logic err);
    tbl.push_back(mk(1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 6'd0, 1'b0, 11'd0, rdy, err));
  endtask

  task automatic apply(input vec_t v, input string tag);
    r_value            = v.r;
    coefficient        = v.c;
    is_new_coefficient = v.stb;
    dc_pred_clr        = v.clr;
    block_ack          = v.ack;
    rd_addr            = v.addr;
    @(posedge clk);
    #1;
    is_new_coefficient = 1'b0;
    dc_pred_clr        = 1'b0;
    block_ack          = 1'b0;
    chk({tag, "_rdy"}, 32'(block_ready), 32'(v.exp_rdy));
    chk({tag, "_err"}, 32'(overflow_err), 32'(v.exp_err));
    if (v.chk_d) chk({tag, "_data"}, 32'(rd_data), 32'(v.exp_d));
  endtask

  task automatic run_table(input string phase);
    foreach (tbl[i]) apply(tbl[i], $sformatf("%s_v%0d", phase, i));
    tbl.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; r_value = '0; coefficient = '0; is_new_coefficient = 1'b0;
    dc_pred_clr = 1'b0; block_ack = 1'b0; rd_addr = '0;
    do_reset();
    chk("reset_rdy", 32'(block_ready), 32'd0);
    chk("reset_err", 32'(overflow_err), 32'd0);
    chk("reset_data", 32'(rd_data), 32'd0);

    // block 1: runs, ZRL, EOB
    pair(4'd0, 8'd2, 0, 0);
    pair(4'd1, 8'hFB, 0, 0);
    pair(4'd3, 8'hFE, 0, 0);
    pair(4'd6, 8'hE0, 0, 0);
    pair(4'd15, 8'd0, 0, 0);
    pair(4'd0, 8'd0, 1, 0);
    rd(6'd0, 11'h002, 1, 0);  rd(6'd8, 11'h7FB, 1, 0);
    rd(6'd3, 11'h7FE, 1, 0);  rd(6'd11, 11'h7E0, 1, 0);
    rd(6'd1, 11'h000, 1, 0);  rd(6'd16, 11'h000, 1, 0);
    rd(6'd2, 11'h000, 1, 0);  rd(6'd63, 11'h000, 1, 0);
    // block 2: prediction 2 + (-3)
    ack(0, 0);
    rd(6'd8, 11'h000, 0, 0);
    pair(4'd0, 8'hFD, 0, 0);
    pair(4'd0, 8'd0, 1, 0);
    rd(6'd0, 11'h7FF, 1, 0);  rd(6'd8, 11'h000, 1, 0);
    // block 3: 64 pairs fill the block without EOB
    ack(0, 0);
    pair(4'd0, 8'd1, 0, 0);
    for (int i = 1; i < 63; i++) pair(4'd0, 8'd1, 0, 0);
    pair(4'd0, 8'd1, 1, 0);
    rd(6'd63, 11'h001, 1, 0); rd(6'd0, 11'h000, 1, 0);
    rd(6'd62, 11'h001, 1, 0); rd(6'd5, 11'h001, 1, 0);
    // block 4: ZRL past the end, then a strobe while full
    ack(0, 0);
    pair(4'd0, 8'd9, 0, 0);
    pair(4'd15, 8'd0, 0, 0);
    pair(4'd15, 8'd0, 0, 0);
    pair(4'd15, 8'd0, 0, 0);
    pair(4'd15, 8'd0, 1, 1);
    pair(4'd0, 8'd7, 1, 1);
    rd(6'd0, 11'h009, 1, 1);  rd(6'd1, 11'h000, 1, 1);
    run_table("a");

    // reset clears the sticky error and the held block
    do_reset();
    rd_addr = 6'd0;
    #1;
    chk("rst2_err", 32'(overflow_err), 32'd0);
    chk("rst2_rdy", 32'(block_ready), 32'd0);
    chk("rst2_data", 32'(rd_data), 32'd0);

    // reset mid-block discards the partial block
    pair(4'd0, 8'd4, 0, 0);
    pair(4'd0, 8'd3, 0, 0);
    rd(6'd1, 11'h003, 0, 0);
    run_table("mid");
    do_reset();
    rd_addr = 6'd0;
    #1;
    chk("mid_rst_d0", 32'(rd_data), 32'd0);
    rd_addr = 6'd1;
    #1;
    chk("mid_rst_d1", 32'(rd_data), 32'd0);

    // predictor clear coincident with a DC pair
    pair(4'd0, 8'd2, 0, 0);
    pair(4'd0, 8'd0, 1, 0);
    rd(6'd0, 11'h002, 1, 0);
    ack(0, 0);
    tbl.push_back(mk(1'b1, 4'd0, 8'd5, 1'b1, 1'b0, 6'd0, 1'b0, 11'd0, 0, 0));
    pair(4'd0, 8'd0, 1, 0);
    rd(6'd0, 11'h005, 1, 0);
    ack(0, 0);
    // predictor wraps modulo 2^11
    for (int i = 1; i <= 9; i++) begin
      tbl.push_back(mk(1'b1, 4'd0, 8'd127, (i == 1), 1'b0, 6'd0, 1'b0, 11'd0, 0, 0));
      pair(4'd0, 8'd0, 1, 0);
      rd(6'd0, 11'((127 * i) % 2048), 1, 0);
      ack(0, 0);
    end
    // ack coincident with the next DC strobe
    pair(4'd0, 8'd1, 0, 0);
    pair(4'd0, 8'd0, 1, 0);
    rd(6'd0, 11'h478, 1, 0);
    tbl.push_back(mk(1'b1, 4'd0, 8'd3, 1'b0, 1'b1, 6'd0, 1'b1, 11'h47B, 0, 0));
    pair(4'd0, 8'd0, 1, 0);
    rd(6'd0, 11'h47B, 1, 0);
`ifdef COEFFICIENT_BLOCK_BUILDER_DOUBLE_BUFFER_EN
    // second block completes while the first is held; ack presents it
    pair(4'd0, 8'd2, 1, 0);
    pair(4'd0, 8'd0, 1, 0);
    rd(6'd0, 11'h47B, 1, 0);
    ack(1, 0);
    rd(6'd0, 11'h47D, 1, 0);
    ack(0, 0);
`else
    // with one bank a strobe while the block is held is dropped
    pair(4'd0, 8'd2, 1, 1);
    rd(6'd0, 11'h47B, 1, 1);
    ack(0, 1);
`endif
    run_table("b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coefficient_block_builder.md
Name: coefficient_block_builder

Overview:
- Downstream neighbour of the Huffman number generator in the JPEG decode path.
- Consumes (run, coefficient) pairs and expands zero runs, including ZRL and EOB.
- Applies DC differential prediction and de-zigzags each 8x8 block into natural row-major order.
- Holds each completed block for the IDCT stage, which reads it randomly and releases it with an acknowledge.

Parameters:
- COEF_W, 11: stored coefficient width in bits; the signed DC predictor width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- r_value  in  4  zero-run length R from the number generator
- coefficient  in  8  signed two's-complement value; the DC difference on the first pair of a block
- is_new_coefficient  in  1  single-cycle strobe: r_value/coefficient valid
- dc_pred_clr  in  1  pulse: zero the DC predictor (scan start / restart marker)
- block_ready  out  1  a complete block is held and readable
- rd_addr  in  6  natural-order index, row*8+col
- rd_data  out  COEF_W  coefficient at rd_addr, combinational
- block_ack  in  1  pulse: consumer done; release the held block
- overflow_err  out  1  sticky error flag; cleared only by rst

Interface decision: one clock; reset is synchronous and active-high.

Behaviour:
- Reset, on rst high at a clk edge: block_ready=0, overflow_err=0, DC predictor=0, zigzag index k=0, valid mask=0, state=FILL.
- Storage:
  - 64 x COEF_W array plus a 64-bit valid mask.
  - rd_data = mem[rd_addr] if mask[rd_addr] is set, else 0.
  - Clearing the mask empties a block in one cycle.
- Zigzag: fixed 64-entry LUT maps k to natural address. Standard JPEG order: k0->0, k1->1, k2->8, k3->16, k4->9, k5->2, k6->3, k7->10, ... k63->63.
- State FILL, on each is_new_coefficient:
  - k=0 (DC):
    - pred <= pred + sext(coefficient), wrapping modulo 2^COEF_W.
    - Store the new pred at zz(0); k <= 1. r_value is ignored.
  - k>0, coefficient!=0:
    - Skip R zeros, storing sext(coefficient) at zz(k+R); k <= k+R+1.
    - If k+R > 63: set overflow_err, store nothing, go to FULL.
  - k>0, R=15, coefficient=0 (ZRL): k <= k+16.
    - If k+16 = 64: go to FULL.
    - If k+16 > 64: set overflow_err, go to FULL.
  - k>0, R=0, coefficient=0 (EOB): go to FULL.
  - Any other zero-coefficient code: treat as EOB.
  - A write that makes k=64: go to FULL.
- Timing of FULL: block_ready rises on the clock edge that accepts the final pair, so it is visible the cycle after the strobe.
- State FULL:
  - block_ready=1; rd_data is stable.
  - is_new_coefficient: the pair is dropped and overflow_err is set (there is no upstream backpressure).
- Release:
  - block_ack in FULL: mask cleared, k=0, block_ready=0, back to FILL at the next edge.
  - block_ack in FILL is ignored.
  - If block_ack and is_new_coefficient arrive in the same cycle, the pair is accepted as the DC of the new block.
- dc_pred_clr:
  - Zeroes the predictor.
  - If it coincides with a DC pair, the pair is added to 0.
  - It does not affect the block contents.
- rst mid-block discards the partial block.

Optional Feature:
- Macro: COEFFICIENT_BLOCK_BUILDER_DOUBLE_BUFFER_EN.
- Defined:
  - Two banks. Fill bank and read bank toggle.
  - On completion, if the other bank is free, filling continues immediately into it.
  - block_ready refers to the read bank; block_ack frees it and presents the next completed bank, if any, on the following cycle.
  - Drop and overflow_err occur only when both banks are full.
- Undefined: single bank, behaviour exactly as above.

Test Plan:
1. Reset, then pairs (R0,+2), (R1,-5), (R3,-2), (R6,-32), ZRL, EOB -> block_ready=1; rd_data at addr 0=2, 8=-5, 3=-2, 11=-32; all other addresses 0.
2. After test 1: block_ack, then (R0,-3), EOB -> addr 0 = -1 (prediction 2-3); addr 8 reads 0 (mask cleared).
3. DC + 63 pairs (R0,+1) -> block_ready set on the 64th pair with no EOB needed; addr 63 = 1; overflow_err=0.
4. DC, then four ZRLs (k=1->65) -> overflow_err=1, block_ready=1; an extra strobe while FULL keeps overflow_err=1 and leaves contents unchanged.
5. dc_pred_clr pulsed with DC pair (R0,+5) after a predictor of 2 -> addr 0 = 5. Separately, DC diff +127 repeated 9 times -> predictor wraps modulo 2048 per COEF_W=11.
6. block_ack coincident with the DC strobe -> pair kept as the new DC. With DOUBLE_BUFFER_EN, a second full block arriving before ack -> no error; after ack, block_ready stays 1 with the second block.
